// File: rtl/uart_frame_rx.sv
// Frame deframer behind a UART receiver: hunts HEADER, buffers a length-prefixed
// payload, verifies the additive checksum and replays clean payloads on a valid/ready stream.
module uart_frame_rx #(
   parameter int unsigned MAX_LEN     = 16,
   parameter logic [7:0]  HEADER      = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_tvalid,
   input  logic [7:0] rx_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic [7:0] m_tdata,
   output logic       m_tlast,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);

   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1'b1);
   localparam logic [TO_W-1:0] TO_ZERO   = TO_W'(1'b0);

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHK     = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t          state_r;
   logic [7:0]      len_r;
   logic [7:0]      sum_r;
   logic [7:0]      wr_cnt_r;
   logic [7:0]      rd_cnt_r;
   logic [TO_W-1:0] to_cnt_r;
   logic [7:0]      buf_r [MAX_LEN];

   logic            to_hit_s;
   logic            len_bad_s;
   logic            buf_we_s;
   logic [7:0]      sum_nxt_s;
   logic [7:0]      rd_nxt_s;

   function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   // Decode helpers shared by the state machine and the buffer write port.
   always_comb begin
      to_hit_s  = (to_cnt_r == TO_LAST);
      len_bad_s = (rx_tdata == 8'd0) || (rx_tdata > MAX_LEN_B);
      buf_we_s  = (state_r == ST_PAYLOAD) && rx_tvalid;
      sum_nxt_s = chk_add(sum_r, rx_tdata);
      rd_nxt_s  = rd_cnt_r + 8'd1;
   end

   // Payload buffer; contents are meaningless outside a frame so it has no reset.
   always_ff @(posedge clk) begin
      if (buf_we_s) begin
         buf_r[wr_cnt_r[IDX_W-1:0]] <= rx_tdata;
      end
   end

   // Frame state machine with all stream and status outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_HUNT;
         len_r     <= 8'd0;
         sum_r     <= 8'd0;
         wr_cnt_r  <= 8'd0;
         rd_cnt_r  <= 8'd0;
         to_cnt_r  <= TO_ZERO;
         m_tvalid  <= 1'b0;
         m_tdata   <= 8'd0;
         m_tlast   <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'd0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         case (state_r)
            ST_HUNT: begin
               if (rx_tvalid && (rx_tdata == HEADER)) begin
                  state_r  <= ST_LEN;
                  sum_r    <= 8'd0;
                  to_cnt_r <= TO_ZERO;
               end
            end
            ST_LEN: begin
               if (rx_tvalid) begin
                  to_cnt_r <= TO_ZERO;
                  if (len_bad_s) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd1;
                     state_r   <= ST_HUNT;
                  end else begin
                     len_r    <= rx_tdata;
                     sum_r    <= rx_tdata;
                     wr_cnt_r <= 8'd0;
                     state_r  <= ST_PAYLOAD;
                  end
               end else if (to_hit_s) begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd3;
                  state_r   <= ST_HUNT;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_ONE;
               end
            end
            ST_PAYLOAD: begin
               if (rx_tvalid) begin
                  to_cnt_r <= TO_ZERO;
                  sum_r    <= sum_nxt_s;
                  wr_cnt_r <= wr_cnt_r + 8'd1;
                  if (wr_cnt_r == (len_r - 8'd1)) begin
                     state_r <= ST_CHK;
                  end
               end else if (to_hit_s) begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd3;
                  state_r   <= ST_HUNT;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_ONE;
               end
            end
            ST_CHK: begin
               if (rx_tvalid) begin
                  to_cnt_r <= TO_ZERO;
                  if (rx_tdata == sum_r) begin
                     frame_ok <= 1'b1;
                     rd_cnt_r <= 8'd0;
                     m_tvalid <= 1'b1;
                     m_tdata  <= buf_r[0];
                     m_tlast  <= (len_r == 8'd1);
                     state_r  <= ST_DRAIN;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd2;
                     state_r   <= ST_HUNT;
                  end
               end else if (to_hit_s) begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd3;
                  state_r   <= ST_HUNT;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_ONE;
               end
            end
            ST_DRAIN: begin
               // The receiver cannot be stalled, so a byte arriving now is lost.
               if (rx_tvalid) begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd0;
               end
               if (m_tvalid && m_tready) begin
                  if (m_tlast) begin
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                     state_r  <= ST_HUNT;
                  end else begin
                     rd_cnt_r <= rd_nxt_s;
                     m_tdata  <= buf_r[rd_nxt_s[IDX_W-1:0]];
                     m_tlast  <= (rd_nxt_s == (len_r - 8'd1));
                  end
               end
            end
            default: begin
               state_r  <= ST_HUNT;
               m_tvalid <= 1'b0;
               m_tlast  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus randomized frames
// checked against a frame-level parse of the sent byte stream.
module tb_uart_frame_rx;

   localparam int         TO  = 40;
   localparam int         ML  = 16;
   localparam logic [7:0] HDR = 8'hA5;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_tvalid = 1'b0;
   logic [7:0] rx_tdata = 8'd0;
   logic       m_tready = 1'b1;
   logic       m_tvalid;
   logic [7:0] m_tdata;
   logic       m_tlast;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   uart_frame_rx #(.MAX_LEN(ML), .HEADER(HDR), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int ok_cnt = 0;
   int ok_cyc = 0;
   int last_rx_cyc = 0;
   int rdy_mode = 0;
   int pat_idx = 0;
   logic [8:0] got_q[$];
   int         got_cyc_q[$];
   logic [1:0] err_q[$];
   logic [8:0] exp_pay_q[$];
   logic [1:0] exp_err_q[$];
   int         exp_ok;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_last = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Consumer ready: 0 always on, 1 random, 2 repeating 1-0-0-1, 3 held low.
   initial begin
      forever begin
         @(posedge clk) #1;
         case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom_range(0, 1));
            2: begin m_tready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); pat_idx++; end
            3: m_tready = 1'b0;
            default: m_tready = 1'b1;
         endcase
      end
   end

   // Output monitor: collects beats and pulses, checks stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            check_value("stall_valid", 32'(m_tvalid), 32'd1);
            check_value("stall_data", 32'(m_tdata), 32'(prev_data));
            check_value("stall_last", 32'(m_tlast), 32'(prev_last));
         end
         if (m_tvalid && m_tready) begin
            got_q.push_back({m_tlast, m_tdata});
            got_cyc_q.push_back(cyc);
         end
         if (frame_ok) begin
            ok_cnt <= ok_cnt + 1;
            ok_cyc <= cyc;
         end
         if (frame_err) err_q.push_back(err_code);
         if (frame_ok || frame_err) check_value("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
         prev_stall <= m_tvalid & ~m_tready;
         prev_data  <= m_tdata;
         prev_last  <= m_tlast;
      end
   end

   // Reference: parse the byte stream by frame rules into expected beats, pulses, codes.
   task automatic model(input bq_t fr);
      int i;
      int len;
      logic [7:0] s;
      exp_pay_q.delete();
      exp_err_q.delete();
      exp_ok = 0;
      i = 0;
      while (i < fr.size()) begin
         if (fr[i] != HDR || i + 1 >= fr.size()) begin
            i++;
            continue;
         end
         len = int'(fr[i+1]);
         i += 2;
         if (len == 0 || len > ML) begin
            exp_err_q.push_back(2'd1);
            continue;
         end
         if (i + len >= fr.size()) break;
         s = 8'(len);
         for (int k = 0; k < len; k++) s = s + fr[i+k];
         if (fr[i+len] == s) begin
            exp_ok++;
            for (int k = 0; k < len; k++) exp_pay_q.push_back({1'(k == len - 1), fr[i+k]});
         end else begin
            exp_err_q.push_back(2'd2);
         end
         i += len + 1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_tvalid = 1'b1;
      rx_tdata  = b;
      @(posedge clk) #1;
      last_rx_cyc = cyc;
      rx_tvalid = 1'b0;
   endtask

   task automatic idle_cyc(input int n);
      repeat (n) @(posedge clk) #1;
   endtask

   task automatic compare(input string tag, input int gb, input int eb, input int ob);
      check_value({tag, ".ok"}, 32'(ok_cnt - ob), 32'(exp_ok));
      check_value({tag, ".nerr"}, 32'(err_q.size() - eb), 32'(exp_err_q.size()));
      for (int k = 0; k < exp_err_q.size(); k++)
         if (eb + k < err_q.size()) check_value({tag, ".code"}, 32'(err_q[eb+k]), 32'(exp_err_q[k]));
      check_value({tag, ".beats"}, 32'(got_q.size() - gb), 32'(exp_pay_q.size()));
      for (int k = 0; k < exp_pay_q.size(); k++)
         if (gb + k < got_q.size()) check_value({tag, ".beat"}, 32'(got_q[gb+k]), 32'(exp_pay_q[k]));
   endtask

   task automatic run_frame(input bq_t fr, input string tag, input int max_gap);
      int gb, eb, ob, w;
      model(fr);
      gb = got_q.size();
      eb = err_q.size();
      ob = ok_cnt;
      foreach (fr[i]) begin
         send_byte(fr[i]);
         if (i != fr.size() - 1) idle_cyc($urandom_range(0, max_gap));
      end
      w = 0;
      while ((got_q.size() - gb) < exp_pay_q.size() && w < 600) begin
         @(posedge clk) #1;
         w++;
      end
      idle_cyc(4);
      compare(tag, gb, eb, ob);
   endtask

   initial begin
      bq_t fr;
      int gb, eb, ob, t0, w, len, kind;
      logic [7:0] s;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_outputs", 32'({m_tvalid, m_tlast, frame_ok, frame_err, err_code, m_tdata}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk) #1;

      // Good frame, back to back with ready high.
      rdy_mode = 0;
      fr = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      run_frame(fr, "good", 0);
      check_value("good.ok_cyc", 32'(ok_cyc), 32'(last_rx_cyc));
      check_value("good.first_cyc", 32'(got_cyc_q[got_cyc_q.size()-3]), 32'(last_rx_cyc));
      check_value("good.span", 32'(got_cyc_q[got_cyc_q.size()-1] - got_cyc_q[got_cyc_q.size()-3]), 32'd2);

      fr = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
      run_frame(fr, "badchk", 1);
      fr = {8'hA5, 8'h01, 8'hFF, 8'h00};
      run_frame(fr, "one", 1);
      fr = {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00};
      run_frame(fr, "len0", 1);
      fr = {8'hA5, 8'h11};
      run_frame(fr, "len17", 1);

      // Full-length frame under 1-0-0-1 backpressure.
      rdy_mode = 2;
      fr = {8'hA5, 8'h10};
      for (int k = 0; k < 16; k++) fr.push_back(8'(k));
      fr.push_back(8'h88);
      run_frame(fr, "bp", 0);
      rdy_mode = 0;

      // Inter-byte timeout.
      eb = err_q.size();
      gb = got_q.size();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h11);
      t0 = cyc;
      w = 0;
      while (!frame_err && w < 100) begin
         @(posedge clk) #1;
         w++;
      end
      check_value("timeout.cycles", 32'(cyc - t0), 32'(TO));
      check_value("timeout.code", 32'(err_code), 32'd3);
      idle_cyc(3);
      check_value("timeout.nerr", 32'(err_q.size() - eb), 32'd1);
      check_value("timeout.beats", 32'(got_q.size() - gb), 32'd0);
      fr = {8'hA5, 8'h02, 8'hA5, 8'h10, 8'hB7};
      run_frame(fr, "after_to", 2);

      // Overrun during a stalled drain.
      rdy_mode = 3;
      idle_cyc(2);
      fr = {8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
      model(fr);
      exp_err_q.push_back(2'd0);
      gb = got_q.size();
      eb = err_q.size();
      ob = ok_cnt;
      foreach (fr[i]) send_byte(fr[i]);
      idle_cyc(2);
      send_byte(8'h55);
      idle_cyc(2);
      rdy_mode = 0;
      w = 0;
      while ((got_q.size() - gb) < exp_pay_q.size() && w < 100) begin
         @(posedge clk) #1;
         w++;
      end
      idle_cyc(4);
      compare("overrun", gb, eb, ob);

      // Reset in the middle of a payload.
      eb = err_q.size();
      ob = ok_cnt;
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h01);
      send_byte(8'h02);
      rst_n = 1'b0;
      @(posedge clk) #1;
      check_value("midrst_outputs", 32'({m_tvalid, m_tlast, frame_ok, frame_err, err_code, m_tdata}), 32'd0);
      rst_n = 1'b1;
      idle_cyc(TO + 5);
      check_value("midrst.nerr", 32'(err_q.size() - eb), 32'd0);
      check_value("midrst.ok", 32'(ok_cnt - ob), 32'd0);
      fr = {8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h1F};
      run_frame(fr, "after_rst", 1);

      // Randomized frames: good, corrupted checksum or illegal length, with noise.
      for (int it = 0; it < 40; it++) begin
         rdy_mode = int'($urandom_range(0, 1));
         fr.delete();
         repeat ($urandom_range(0, 3)) begin
            s = 8'($urandom_range(0, 255));
            if (s == HDR) s = 8'h5A;
            fr.push_back(s);
         end
         fr.push_back(HDR);
         kind = int'($urandom_range(0, 9));
         if (kind == 1) begin
            fr.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(ML + 1, 255)));
         end else begin
            len = int'($urandom_range(1, ML));
            fr.push_back(8'(len));
            s = 8'(len);
            for (int k = 0; k < len; k++) begin
               fr.push_back(8'($urandom_range(0, 255)));
               s = s + fr[fr.size()-1];
            end
            fr.push_back((kind == 0) ? (s ^ 8'(1 << $urandom_range(0, 7))) : s);
         end
         run_frame(fr, "rand", 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
